// File: rtl/alu_issue_pkg.sv
// Shared RV32I issue-stage types: ALU operations, compare post-select,
// opcode constants and the decoded entry that travels to execute.
package rvcpu;

    localparam int XLEN = 32;

    // alu_pass_b sits in an otherwise unused encoding; the ALU default path returns b.
    typedef enum logic [3:0] {
        alu_add    = 4'h0,
        alu_sub    = 4'h1,
        alu_sll    = 4'h2,
        alu_xor    = 4'h3,
        alu_srl    = 4'h4,
        alu_sra    = 4'h5,
        alu_or     = 4'h6,
        alu_and    = 4'h7,
        alu_pass_b = 4'hF
    } alu_op_t;

    // Execute turns the subtract flags into a 0/1 result when cmp is not none.
    typedef enum logic [1:0] {
        cmp_none = 2'd0,
        cmp_slt  = 2'd1,
        cmp_sltu = 2'd2
    } cmp_kind_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        alu_op_t         op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [4:0]      rd;
        logic            we;
        cmp_kind_t       cmp;
        logic            illegal;
    } issue_entry_t;

    // Idle payload: also the shape of an illegal entry before rd is filled in.
    localparam issue_entry_t ENTRY_IDLE = '{
        op:      alu_add,
        a:       '0,
        b:       '0,
        rd:      5'd0,
        we:      1'b0,
        cmp:     cmp_none,
        illegal: 1'b0
    };

    typedef enum logic [1:0] {
        buf_empty = 2'd0,
        buf_one   = 2'd1,
        buf_two   = 2'd2
    } buf_state_t;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational RV32I decode of OP / OP-IMM / LUI / AUIPC into an issue entry.
// Only routes operands; no arithmetic happens here.
module alu_issue_decode
    import rvcpu::*;
#(
    parameter int Width = 32
) (
    input  logic [31:0]      instr,
    input  logic [Width-1:0] pc,
    input  logic [Width-1:0] rs1_data,
    input  logic [Width-1:0] rs2_data,
    output issue_entry_t     entry
);

    logic [6:0]       opcode;
    logic [2:0]       f3;
    logic [6:0]       f7;
    logic [4:0]       rd;
    logic [Width-1:0] imm_i;
    logic [Width-1:0] imm_u;
    logic [Width-1:0] shamt;
    logic             legal;
    logic             unused_rs1_field;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];
    assign rd     = instr[11:7];
    assign imm_i  = {{(Width-12){instr[31]}}, instr[31:20]};
    assign imm_u  = {instr[31:12], 12'b0};
    assign shamt  = {{(Width-5){1'b0}}, instr[24:20]};

    // The rs1 index field is consumed by the register file, not by this stage.
    assign unused_rs1_field = ^instr[19:15];

    // Opcode/funct decode; illegal encodings collapse to an inert add of zeros.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path can infer a latch.
        entry    = ENTRY_IDLE;
        entry.rd = rd;
        legal    = 1'b1;

        case (opcode)
            OPC_OP: begin
                entry.a = rs1_data;
                entry.b = rs2_data;
                case (f3)
                    3'b000: begin
                        if (f7 == F7_ZERO)     entry.op = alu_add;
                        else if (f7 == F7_ALT) entry.op = alu_sub;
                        else                   legal    = 1'b0;
                    end
                    3'b001: begin entry.op = alu_sll; legal = (f7 == F7_ZERO); end
                    3'b010: begin entry.op = alu_sub; entry.cmp = cmp_slt;  legal = (f7 == F7_ZERO); end
                    3'b011: begin entry.op = alu_sub; entry.cmp = cmp_sltu; legal = (f7 == F7_ZERO); end
                    3'b100: begin entry.op = alu_xor; legal = (f7 == F7_ZERO); end
                    3'b101: begin
                        if (f7 == F7_ZERO)     entry.op = alu_srl;
                        else if (f7 == F7_ALT) entry.op = alu_sra;
                        else                   legal    = 1'b0;
                    end
                    3'b110: begin entry.op = alu_or;  legal = (f7 == F7_ZERO); end
                    3'b111: begin entry.op = alu_and; legal = (f7 == F7_ZERO); end
                endcase
            end

            OPC_OP_IMM: begin
                entry.a = rs1_data;
                entry.b = imm_i;
                case (f3)
                    3'b000: entry.op = alu_add;
                    3'b010: begin entry.op = alu_sub; entry.cmp = cmp_slt;  end
                    3'b011: begin entry.op = alu_sub; entry.cmp = cmp_sltu; end
                    3'b100: entry.op = alu_xor;
                    3'b110: entry.op = alu_or;
                    3'b111: entry.op = alu_and;
                    3'b001: begin
                        entry.op = alu_sll;
                        entry.b  = shamt;
                        legal    = (f7 == F7_ZERO);
                    end
                    3'b101: begin
                        entry.b = shamt;
                        if (f7 == F7_ZERO)     entry.op = alu_srl;
                        else if (f7 == F7_ALT) entry.op = alu_sra;
                        else                   legal    = 1'b0;
                    end
                endcase
            end

            OPC_LUI: begin
                entry.op = alu_pass_b;
                entry.b  = imm_u;
            end

            OPC_AUIPC: begin
                entry.op = alu_add;
                entry.a  = pc;
                entry.b  = imm_u;
            end

            default: legal = 1'b0;
        endcase

        if (!legal) begin
            entry         = ENTRY_IDLE;
            entry.rd      = rd;
            entry.illegal = 1'b1;
        end else begin
            // Writes to x0 are architecturally discarded.
            entry.we = (rd != 5'd0);
        end
    end

endmodule

// File: rtl/alu_issue.sv
// Issue stage: decodes one instruction per cycle into a 2-entry skid buffer
// whose head drives the execute-stage ALU directly.
module alu_issue
    import rvcpu::*;
#(
    parameter int Width = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [Width-1:0] in_pc,
    input  logic [Width-1:0] in_rs1_data,
    input  logic [Width-1:0] in_rs2_data,
    output logic             out_valid,
    input  logic             out_ready,
    output alu_op_t          out_op,
    output logic [Width-1:0] out_a,
    output logic [Width-1:0] out_b,
    output logic [4:0]       out_rd,
    output logic             out_we,
    output cmp_kind_t        out_cmp,
    output logic             out_illegal
);

    buf_state_t   state_q;
    buf_state_t   state_d;
    issue_entry_t dec_entry;
    issue_entry_t head_q;
    issue_entry_t skid_q;
    logic         accept;
    logic         retire;
    logic         load_head_in;
    logic         load_head_skid;
    logic         load_skid;

    alu_issue_decode #(
        .Width(Width)
    ) u_decode (
        .instr    (in_instr),
        .pc       (in_pc),
        .rs1_data (in_rs1_data),
        .rs2_data (in_rs2_data),
        .entry    (dec_entry)
    );

    // Both handshake outputs are pure decodes of the state register.
    assign in_ready  = (state_q != buf_two);
    assign out_valid = (state_q != buf_empty);
    assign accept    = in_valid && in_ready;
    assign retire    = out_valid && out_ready;

    // Next-state and entry-register load selection; flush wins over everything.
    always_comb begin
        state_d        = state_q;
        load_head_in   = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;

        if (flush) begin
            state_d = buf_empty;
        end else begin
            case (state_q)
                buf_empty: begin
                    if (accept) begin
                        load_head_in = 1'b1;
                        state_d      = buf_one;
                    end
                end
                buf_one: begin
                    case ({accept, retire})
                        2'b10: begin
                            load_skid = 1'b1;
                            state_d   = buf_two;
                        end
                        2'b01: state_d = buf_empty;
                        2'b11: load_head_in = 1'b1;
                        default: ;
                    endcase
                end
                buf_two: begin
                    if (retire) begin
                        load_head_skid = 1'b1;
                        state_d        = buf_one;
                    end
                end
                default: state_d = buf_empty;
            endcase
        end
    end

    // Buffer occupancy register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
        if (!rst_n) state_q <= buf_empty;
        else        state_q <= state_d;
    end

    // Head and skid entry registers; the head feeds the ALU inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the payload registers are reset because the ALU sees the head even when out_valid is low.
        if (!rst_n) begin
            head_q <= ENTRY_IDLE;
            skid_q <= ENTRY_IDLE;
        end else begin
            if (load_head_in)        head_q <= dec_entry;
            else if (load_head_skid) head_q <= skid_q;
            if (load_skid)           skid_q <= dec_entry;
        end
    end

    assign out_op      = head_q.op;
    assign out_a       = head_q.a;
    assign out_b       = head_q.b;
    assign out_rd      = head_q.rd;
    assign out_we      = head_q.we;
    assign out_cmp     = head_q.cmp;
    assign out_illegal = head_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: expected entries are queued when an
// instruction is accepted and compared when the DUT retires one.
module tb_alu_issue;
    import rvcpu::*;

    localparam logic [31:0] R1 = 32'h8000_0001;
    localparam logic [31:0] R2 = 32'h0000_0011;
    localparam logic [31:0] PC = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic [31:0] in_rs1_data = '0;
    logic [31:0] in_rs2_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    alu_op_t     out_op;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [4:0]  out_rd;
    logic        out_we;
    cmp_kind_t   out_cmp;
    logic        out_illegal;

    int           vectors = 0;
    int           miscompares = 0;
    issue_entry_t sb[$];
    issue_entry_t pending;

    alu_issue #(.Width(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .in_rs1_data (in_rs1_data),
        .in_rs2_data (in_rs2_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_op      (out_op),
        .out_a       (out_a),
        .out_b       (out_b),
        .out_rd      (out_rd),
        .out_we      (out_we),
        .out_cmp     (out_cmp),
        .out_illegal (out_illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic issue_entry_t mk(alu_op_t op, logic [31:0] a, logic [31:0] b,
                                        logic [4:0] rd, logic we, cmp_kind_t cmp, logic ill);
        issue_entry_t e;
        e.op = op; e.a = a; e.b = b; e.rd = rd; e.we = we; e.cmp = cmp; e.illegal = ill;
        return e;
    endfunction

    function automatic logic [31:0] r_type(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                           logic [2:0] f3, logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OPC_OP};
    endfunction

    function automatic logic [31:0] i_type(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                           logic [4:0] rd);
        return {imm, rs1, f3, rd, OPC_OP_IMM};
    endfunction

    function automatic issue_entry_t observed();
        issue_entry_t o;
        o.op = out_op; o.a = out_a; o.b = out_b; o.rd = out_rd;
        o.we = out_we; o.cmp = out_cmp; o.illegal = out_illegal;
        return o;
    endfunction

    // One clock: score the handshakes seen mid-cycle, then advance to 1 ns past the edge.
    task automatic cycle(output logic acc);
        logic         ret;
        issue_entry_t obs;
        issue_entry_t exp;
        acc = in_valid && in_ready && !flush;
        ret = out_valid && out_ready && !flush;
        if (ret) begin
            obs = observed();
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL retire_unexpected: got entry %h, required no retirement", obs);
            end else begin
                exp = sb.pop_front();
                if (obs !== exp) begin
                    miscompares++;
                    $display("FAIL retire_entry: got %h, required %h", obs, exp);
                end
            end
        end
        if (acc) sb.push_back(pending);
        if (flush) sb.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] rs1,
                        input logic [31:0] rs2, input issue_entry_t exp, output int waited);
        logic acc;
        in_valid    = 1'b1;
        in_instr    = instr;
        in_pc       = pc;
        in_rs1_data = rs1;
        in_rs2_data = rs2;
        pending     = exp;
        waited      = 0;
        acc         = 1'b0;
        while (!acc && waited < 40) begin
            cycle(acc);
            waited++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: instr %h not accepted in %0d cycles", instr, waited);
        end
    endtask

    task automatic drain();
        logic acc;
        int   n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (sb.size() != 0 && n < 40) begin
            cycle(acc);
            n++;
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain_timeout: got %0d entries left, required 0", sb.size());
            sb.delete();
        end
        // Idle cycles: any further retirement is a duplicate or a leaked entry.
        repeat (3) cycle(acc);
    endtask

    // Pipelined send with out_ready=1: every instruction must go in on its first cycle.
    task automatic stream(input logic [31:0] instr, input issue_entry_t exp);
        int w;
        send(instr, PC, R1, R2, exp, w);
        vectors++;
        if (w !== 1) begin
            miscompares++;
            $display("FAIL throughput: instr %h took %0d cycles, required 1", instr, w);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        vectors += 6;
        if (in_ready !== 1'b1)  begin miscompares++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
        if (out_op !== alu_add) begin miscompares++; $display("FAIL reset_op: got %h, required %h", out_op, alu_add); end
        if (out_a !== 32'h0)    begin miscompares++; $display("FAIL reset_a: got %h, required 0", out_a); end
        if (out_b !== 32'h0)    begin miscompares++; $display("FAIL reset_b: got %h, required 0", out_b); end
        if (out_cmp !== cmp_none) begin miscompares++; $display("FAIL reset_cmp: got %h, required %h", out_cmp, cmp_none); end
    endtask

    task automatic test_decode_basic();
        int w;
        out_ready = 1'b1;
        send(32'h002081B3, PC, 32'd5, 32'd7, mk(alu_add, 32'd5, 32'd7, 5'd3, 1'b1, cmp_none, 1'b0), w);
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL latency: out_valid got %b one cycle after accept, required 1", out_valid);
        end
        send(32'hFFF00093, PC, 32'h0, 32'h0, mk(alu_add, 32'h0, 32'hFFFF_FFFF, 5'd1, 1'b1, cmp_none, 1'b0), w);
        send(32'h123452B7, PC, 32'h0, 32'h0, mk(alu_pass_b, 32'h0, 32'h1234_5000, 5'd5, 1'b1, cmp_none, 1'b0), w);
        send(32'h4030D213, PC, 32'h8000_0000, 32'h0, mk(alu_sra, 32'h8000_0000, 32'd3, 5'd4, 1'b1, cmp_none, 1'b0), w);
        drain();
    endtask

    task automatic test_op_table();
        out_ready = 1'b1;
        stream(r_type(7'h20, 5'd2, 5'd1, 3'd0, 5'd6),  mk(alu_sub, R1, R2, 5'd6,  1'b1, cmp_none, 1'b0));
        stream(r_type(7'h00, 5'd2, 5'd1, 3'd1, 5'd7),  mk(alu_sll, R1, R2, 5'd7,  1'b1, cmp_none, 1'b0));
        stream(r_type(7'h00, 5'd2, 5'd1, 3'd2, 5'd8),  mk(alu_sub, R1, R2, 5'd8,  1'b1, cmp_slt,  1'b0));
        stream(r_type(7'h00, 5'd2, 5'd1, 3'd3, 5'd9),  mk(alu_sub, R1, R2, 5'd9,  1'b1, cmp_sltu, 1'b0));
        stream(r_type(7'h00, 5'd2, 5'd1, 3'd4, 5'd10), mk(alu_xor, R1, R2, 5'd10, 1'b1, cmp_none, 1'b0));
        stream(r_type(7'h00, 5'd2, 5'd1, 3'd5, 5'd11), mk(alu_srl, R1, R2, 5'd11, 1'b1, cmp_none, 1'b0));
        stream(r_type(7'h00, 5'd2, 5'd1, 3'd6, 5'd12), mk(alu_or,  R1, R2, 5'd12, 1'b1, cmp_none, 1'b0));
        stream(r_type(7'h00, 5'd2, 5'd1, 3'd7, 5'd13), mk(alu_and, R1, R2, 5'd13, 1'b1, cmp_none, 1'b0));
        stream(i_type(12'h800, 5'd1, 3'd2, 5'd14), mk(alu_sub, R1, 32'hFFFF_F800, 5'd14, 1'b1, cmp_slt,  1'b0));
        stream(i_type(12'h7FF, 5'd1, 3'd3, 5'd15), mk(alu_sub, R1, 32'h0000_07FF, 5'd15, 1'b1, cmp_sltu, 1'b0));
        stream(i_type(12'h0F0, 5'd1, 3'd4, 5'd20), mk(alu_xor, R1, 32'h0000_00F0, 5'd20, 1'b1, cmp_none, 1'b0));
        stream(i_type(12'hFFF, 5'd1, 3'd6, 5'd21), mk(alu_or,  R1, 32'hFFFF_FFFF, 5'd21, 1'b1, cmp_none, 1'b0));
        stream(i_type(12'h055, 5'd1, 3'd7, 5'd22), mk(alu_and, R1, 32'h0000_0055, 5'd22, 1'b1, cmp_none, 1'b0));
        stream(i_type(12'h01F, 5'd1, 3'd1, 5'd16), mk(alu_sll, R1, 32'd31, 5'd16, 1'b1, cmp_none, 1'b0));
        stream(i_type(12'h005, 5'd1, 3'd5, 5'd17), mk(alu_srl, R1, 32'd5,  5'd17, 1'b1, cmp_none, 1'b0));
        stream({20'hABCDE, 5'd18, OPC_AUIPC},      mk(alu_add, PC, 32'hABCD_E000, 5'd18, 1'b1, cmp_none, 1'b0));
        drain();
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        stream(32'h0000_0000, mk(alu_add, 32'h0, 32'h0, 5'd0, 1'b0, cmp_none, 1'b1));
        stream(32'h4020_91B3, mk(alu_add, 32'h0, 32'h0, 5'd3, 1'b0, cmp_none, 1'b1));
        stream(32'h0000_0033, mk(alu_add, R1, R2, 5'd0, 1'b0, cmp_none, 1'b0));
        stream(i_type(12'h405, 5'd1, 3'd1, 5'd19), mk(alu_add, 32'h0, 32'h0, 5'd19, 1'b0, cmp_none, 1'b1));
        stream(r_type(7'h20, 5'd2, 5'd1, 3'd2, 5'd23), mk(alu_add, 32'h0, 32'h0, 5'd23, 1'b0, cmp_none, 1'b1));
        stream({25'h0, 7'b1100011}, mk(alu_add, 32'h0, 32'h0, 5'd0, 1'b0, cmp_none, 1'b1));
        drain();
    endtask

    task automatic test_back_to_back();
        issue_entry_t e1, e2, e3;
        logic         acc;
        int           w;
        e1 = mk(alu_add, R1, R2, 5'd1, 1'b1, cmp_none, 1'b0);
        e2 = mk(alu_xor, R1, R2, 5'd2, 1'b1, cmp_none, 1'b0);
        e3 = mk(alu_and, R1, R2, 5'd3, 1'b1, cmp_none, 1'b0);
        out_ready = 1'b0;
        send(r_type(7'h00, 5'd2, 5'd1, 3'd0, 5'd1), PC, R1, R2, e1, w);
        send(r_type(7'h00, 5'd2, 5'd1, 3'd4, 5'd2), PC, R1, R2, e2, w);
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL full_in_ready: got %b, required 0", in_ready);
        end
        in_valid    = 1'b1;
        in_instr    = r_type(7'h00, 5'd2, 5'd1, 3'd7, 5'd3);
        in_rs1_data = R1;
        in_rs2_data = R2;
        pending     = e3;
        for (int i = 0; i < 3; i++) begin
            cycle(acc);
            vectors += 2;
            if (acc) begin
                miscompares++;
                $display("FAIL held_third: accepted while full, required held");
            end
            if (observed() !== e1 || out_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL stall_stable: got %h valid %b, required %h valid 1", observed(), out_valid, e1);
            end
        end
        out_ready = 1'b1;
        send(r_type(7'h00, 5'd2, 5'd1, 3'd7, 5'd3), PC, R1, R2, e3, w);
        drain();
    endtask

    task automatic test_flush();
        logic acc;
        int   w;
        out_ready = 1'b0;
        send(r_type(7'h00, 5'd2, 5'd1, 3'd6, 5'd4), PC, R1, R2, mk(alu_or, R1, R2, 5'd4, 1'b1, cmp_none, 1'b0), w);
        send(r_type(7'h00, 5'd2, 5'd1, 3'd7, 5'd5), PC, R1, R2, mk(alu_and, R1, R2, 5'd5, 1'b1, cmp_none, 1'b0), w);
        flush     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = r_type(7'h00, 5'd2, 5'd1, 3'd1, 5'd6);
        pending   = mk(alu_sll, R1, R2, 5'd6, 1'b1, cmp_none, 1'b0);
        cycle(acc);
        flush    = 1'b0;
        in_valid = 1'b0;
        vectors += 2;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_out_valid: got %b, required 0", out_valid); end
        if (in_ready !== 1'b1)  begin miscompares++; $display("FAIL flush_in_ready: got %b, required 1", in_ready); end
        send(r_type(7'h20, 5'd2, 5'd1, 3'd5, 5'd7), PC, R1, R2, mk(alu_sra, R1, R2, 5'd7, 1'b1, cmp_none, 1'b0), w);
        drain();
    endtask

    task automatic test_reset_in_two();
        int w;
        out_ready = 1'b0;
        send(r_type(7'h00, 5'd2, 5'd1, 3'd4, 5'd8), PC, R1, R2, mk(alu_xor, R1, R2, 5'd8, 1'b1, cmp_none, 1'b0), w);
        send(r_type(7'h00, 5'd2, 5'd1, 3'd6, 5'd9), PC, R1, R2, mk(alu_or, R1, R2, 5'd9, 1'b1, cmp_none, 1'b0), w);
        #2 rst_n = 1'b0;
        #1;
        sb.delete();
        vectors += 3;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL async_reset_valid: got %b, required 0", out_valid); end
        if (out_op !== alu_add) begin miscompares++; $display("FAIL async_reset_op: got %h, required %h", out_op, alu_add); end
        if (out_a !== 32'h0)    begin miscompares++; $display("FAIL async_reset_a: got %h, required 0", out_a); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        vectors += 2;
        if (in_ready !== 1'b1)  begin miscompares++; $display("FAIL post_reset_in_ready: got %b, required 1", in_ready); end
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL post_reset_out_valid: got %b, required 0", out_valid); end
        out_ready = 1'b1;
        send(r_type(7'h00, 5'd2, 5'd1, 3'd3, 5'd10), PC, R1, R2, mk(alu_sub, R1, R2, 5'd10, 1'b1, cmp_sltu, 1'b0), w);
        drain();
    endtask

    initial begin
        test_reset();
        test_decode_basic();
        test_op_table();
        test_illegal();
        test_back_to_back();
        test_flush();
        test_reset_in_two();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Issue stage in front of the execute-stage ALU.
- Takes a fetched RV32I instruction word plus register-file read data and decodes OP, OP-IMM, LUI and AUIPC into an ALU operation, operand A/B, destination and write-enable.
- Holds decoded entries in a 2-entry skid buffer with valid/ready on both sides, so in_ready is a registered signal.
- Sits between decode/regfile read and execute; its outputs drive the ALU op, a and b inputs directly.

Parameters:
- Width, 32, datapath width (XLEN); must be 32 for RV32I.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous kill of all buffered entries
- in_valid  in  1  instruction presented
- in_ready  out  1  stage can accept
- in_instr  in  32  instruction word
- in_pc  in  Width  instruction PC
- in_rs1_data  in  Width  rs1 read value
- in_rs2_data  in  Width  rs2 read value
- out_valid  out  1  decoded entry available
- out_ready  in  1  execute accepts the entry
- out_op  out  rvcpu::alu_op_t  ALU operation
- out_a  out  Width  operand A
- out_b  out  Width  operand B
- out_rd  out  5  destination register
- out_we  out  1  register write-enable
- out_cmp  out  rvcpu::cmp_kind_t  result post-select: none / slt / sltu
- out_illegal  out  1  unsupported encoding

Behaviour:
- Reset (async, rst_n low):
  - Buffer becomes EMPTY; out_valid=0; in_ready=1 from the first clock after reset release.
  - All payload outputs are 0: op=alu_add, cmp=none.
  - Reset mid-operation discards all entries.
- Handshakes:
  - Accept when in_valid && in_ready.
  - Retire when out_valid && out_ready.
  - Entries leave in arrival order.
  - Payload outputs are stable while out_valid && !out_ready.
- Buffer state machine:
  - EMPTY (in_ready=1, out_valid=0): accept -> ONE.
  - ONE (in_ready=1, out_valid=1): accept and no retire -> TWO; retire and no accept -> EMPTY; both -> ONE, with the new entry at the head the next cycle.
  - TWO (in_ready=0, out_valid=1): retire -> ONE; the skid entry moves to the head.
- Latency:
  - An entry accepted in cycle N appears on out_* in cycle N+1 if the buffer holds no older entry.
  - Throughput is 1 per cycle when out_ready=1.
- Flush:
  - Next state is EMPTY; out_valid=0 the next cycle.
  - Flush dominates an in_valid or out_ready in the same cycle; the incoming instruction is dropped.
- Decode rules:
  - imm_i = sign-extended instr[31:20].
  - shamt = zero-extended instr[24:20].
  - rd = instr[11:7].
- OP (0110011), a=rs1, b=rs2:
  - f3=000: f7=0000000 -> alu_add; f7=0100000 -> alu_sub.
  - 001 -> alu_sll; 100 -> alu_xor; 110 -> alu_or; 111 -> alu_and. These require f7=0.
  - 101: f7=0 -> alu_srl; f7=0100000 -> alu_sra.
  - 010 -> alu_sub with cmp=slt; 011 -> alu_sub with cmp=sltu. Execute forms the 0/1 result from the flags.
- OP-IMM (0010011), a=rs1:
  - b=imm_i for addi, slti, sltiu, xori, ori, andi.
  - b=shamt for slli/srli/srai; instr[31:25] must be 0000000, or 0100000 for srai.
- LUI (0110111): op=alu_pass_b, a=0, b={instr[31:12],12'b0}.
- AUIPC (0010111): op=alu_add, a=pc, b={instr[31:12],12'b0}.
- Illegal:
  - Covers any other opcode, or a reserved f7/f3 combination.
  - Sets illegal=1, we=0, op=alu_add, a=b=0.
  - The entry still flows through in order.
- rd=0 forces we=0.
- No arithmetic is performed in this block.

Decomposition:
- rvcpu package gains:
  - cmp_kind_t enum {cmp_none, cmp_slt, cmp_sltu}.
  - alu_pass_b constant in an unused alu_op_t encoding; the ALU default path returns b.
  - Opcode constants OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC.
  - Packed struct issue_entry_t holding op, a, b, rd, we, cmp, illegal.
- One sub-module, alu_issue_decode: purely combinational instr/operands -> issue_entry_t.
- The top holds the skid-buffer state machine and the two entry registers.

Test Plan:
- Reset then idle -> in_ready=1, out_valid=0, out_op=alu_add, out_a=out_b=0.
- instr 0x002081B3 (add x3,x1,x2), rs1=5, rs2=7, out_ready=1 -> next cycle: op=alu_add, a=5, b=7, rd=3, we=1, cmp=none.
- instr 0xFFF00093 (addi x1,x0,-1) -> b=0xFFFFFFFF. Then 0x123452B7 (lui x5) -> op=alu_pass_b, b=0x12345000, rd=5. Then 0x4030D213 (srai x4,x1,3) -> op=alu_sra, b=3.
- out_ready=0 with 3 back-to-back valid instructions:
  - First two are accepted; in_ready=0 in cycle 2 and the third is held.
  - Raise out_ready: outputs retire in order 1, 2, 3; no loss or duplication.
- Buffer in TWO, assert flush together with in_valid -> next cycle out_valid=0, in_ready=1, dropped instruction never appears. Separately, rst_n low in TWO -> immediately out_valid=0.
- instr 0x00000000 -> illegal=1, we=0. instr 0x402091B3 (f3=001, f7=0100000) -> illegal=1. instr 0x00000033 (add x0) -> we=0.
